// File: rtl/mbt_pkg.sv
// Shared state encoding, default number formats and step helper for the
// Mandelbrot lane engine.
package mbt_pkg;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} mbt_state_e;

    localparam int MBT_Q      = 21;
    localparam int MBT_N      = 32;
    localparam int MBT_ITER_W = 7;

    // Pixel step as a Q-format increment: 2^-(step_shift+zoom); zero if finer than one LSB.
    function automatic logic [63:0] mbt_step(input int q, input int step_shift,
                                             input logic [1:0] zoom);
        int sh;
        sh = q - step_shift - int'(zoom);
        return (sh < 0) ? 64'd0 : (64'd1 << sh);
    endfunction

endpackage

// File: rtl/mbt_alu.sv
// Escape-time iteration lane: z <- z^2 + c from z=0 until |z|^2 > 4 or the
// count saturates; valid and d_out then hold until the next start.
module mbt_alu
    import mbt_pkg::*;
#(
    parameter int N      = MBT_N,
    parameter int Q      = MBT_Q,
    parameter int ITER_W = MBT_ITER_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] c_re,
    input  logic signed [N-1:0] c_im,
    output logic                valid,
    output logic [ITER_W-1:0]   d_out
);

    localparam logic signed [2*N-1:0] ESC_LIM = (2*N)'(4) <<< (2*Q);

    logic signed [N-1:0]   cr_q, ci_q, zr_q, zi_q, zr_nx, zi_nx;
    logic signed [2*N-1:0] zr_w, zi_w, zr2, zi2, zri;
    logic [ITER_W-1:0]     n_q;
    logic                  run_q, finish;

    always_comb begin
        zr_w  = zr_q;
        zi_w  = zi_q;
        zr2   = zr_w * zr_w;
        zi2   = zi_w * zi_w;
        zri   = zr_w * zi_w;
        zr_nx = N'((zr2 - zi2) >>> Q) + cr_q;
        zi_nx = N'(zri >>> (Q - 1)) + ci_q;
    end

    assign finish = run_q && (((zr2 + zi2) > ESC_LIM) || (n_q == '1));
    assign d_out  = n_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            valid <= 1'b0;
        end else if (start) begin
            run_q <= 1'b1;
            valid <= 1'b0;
        end else if (finish) begin
            run_q <= 1'b0;
            valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            cr_q <= c_re;
            ci_q <= c_im;
            zr_q <= '0;
            zi_q <= '0;
            n_q  <= '0;
        end else if (run_q && !finish) begin
            zr_q <= zr_nx;
            zi_q <= zi_nx;
            n_q  <= n_q + ITER_W'(1);
        end
    end

endmodule

// File: rtl/mbt_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner when the grant is taken.
module mbt_rr_arbiter #(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] req,
    input  logic             accept,
    output logic [LANES-1:0] grant
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [PW-1:0] ptr_q;
    int            win;
    int            idx;

    // Scan from furthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        grant = '0;
        win   = 0;
        idx   = 0;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % LANES;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept && (|req)) begin
            ptr_q <= PW'((win + 1) % LANES);
        end
    end

endmodule

// File: rtl/mbt_lane_engine.sv
// Mandelbrot frame engine: scans the pixel grid, dispatches to idle lanes and
// writes tagged results out of order. MBT_PERF_CNT_EN adds perf counters.
module mbt_lane_engine
    import mbt_pkg::*;
#(
    parameter int Q          = MBT_Q,
    parameter int N          = MBT_N,
    parameter int LANES      = 4,
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int ADDR_W     = 17,
    parameter int ITER_W     = MBT_ITER_W,
    parameter int STEP_SHIFT = 7
) (
    input  logic                clk_fast,
    input  logic                rst,
    input  logic                frame_start,
    input  logic signed [N-1:0] x_min,
    input  logic signed [N-1:0] y_max,
    input  logic [1:0]          zoom_level,
    output logic                busy,
    output logic                done,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [ITER_W-1:0]   wr_data
`ifdef MBT_PERF_CNT_EN
    ,
    output logic [31:0]         perf_cycles,
    output logic [31:0]         perf_stall
`endif
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    mbt_state_e          state_q, state_d;
    logic signed [N-1:0] x_min_q, step_q, c_re_q, c_im_q;
    logic [XW-1:0]       i_x_q;
    logic [YW-1:0]       i_y_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LANES-1:0]    lane_busy_q, lane_out_q, lane_start, lane_valid;
    logic [LANES-1:0]    lane_req, lane_grant, lane_release;
    logic [ADDR_W-1:0]   lane_tag_q [LANES];
    logic [ITER_W-1:0]   lane_data  [LANES];
    logic [ADDR_W-1:0]   sel_addr;
    logic [ITER_W-1:0]   sel_data;
    logic                accept, load, dispatch, row_end, last_pix, frame_acc;

    assign frame_acc    = (state_q == IDLE) && frame_start;
    assign accept       = wr_valid && wr_ready;
    assign lane_release = accept ? lane_out_q : '0;
    assign lane_req     = lane_busy_q & lane_valid & ~lane_out_q;
    assign load         = (|lane_req) && (!wr_valid || accept);
    assign row_end      = (i_x_q == XW'(H_RES - 1));
    assign last_pix     = row_end && (i_y_q == YW'(V_RES - 1));
    assign dispatch     = |lane_start;
    assign busy         = (state_q == DISPATCH) || (state_q == DRAIN);
    assign done         = (state_q == DONE);

    // A lane waiting on its write is still busy, so it cannot be re-dispatched
    // in the cycle its release happens.
    always_comb begin
        lane_start = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (!lane_busy_q[i]) begin
                lane_start    = '0;
                lane_start[i] = 1'b1;
            end
        end
        if (state_q != DISPATCH) lane_start = '0;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_grant[i]) begin
                sel_addr = sel_addr | lane_tag_q[i];
                sel_data = sel_data | lane_data[i];
            end
        end
    end

    // DRAIN looks at next-cycle occupancy so done lands right after the final write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (frame_start) state_d = DISPATCH;
            DISPATCH: if (dispatch && last_pix) state_d = DRAIN;
            DRAIN:    if (((lane_busy_q & ~lane_release) == '0) &&
                          !(load || (wr_valid && !accept))) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lane_busy_q <= '0;
            lane_out_q  <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            state_q     <= state_d;
            lane_busy_q <= (lane_busy_q & ~lane_release) | lane_start;
            if (load) begin
                wr_valid   <= 1'b1;
                wr_addr    <= sel_addr;
                wr_data    <= sel_data;
                lane_out_q <= lane_grant;
            end else if (accept) begin
                wr_valid   <= 1'b0;
                lane_out_q <= '0;
            end
        end
    end

    // Scan coordinates advance incrementally; all sums wrap modulo 2^N.
    always_ff @(posedge clk_fast) begin
        if (frame_acc) begin
            x_min_q <= x_min;
            step_q  <= N'(mbt_step(Q, STEP_SHIFT, zoom_level));
            c_re_q  <= x_min;
            c_im_q  <= y_max;
            i_x_q   <= '0;
            i_y_q   <= '0;
            addr_q  <= '0;
        end else if (dispatch) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (row_end) begin
                c_re_q <= x_min_q;
                c_im_q <= c_im_q - step_q;
                i_x_q  <= '0;
                i_y_q  <= i_y_q + YW'(1);
            end else begin
                c_re_q <= c_re_q + step_q;
                i_x_q  <= i_x_q + XW'(1);
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (lane_start[i]) lane_tag_q[i] <= addr_q;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mbt_alu #(.N(N), .Q(Q), .ITER_W(ITER_W)) u_alu (
            .clk   (clk_fast),
            .rst   (rst),
            .start (lane_start[g]),
            .c_re  (c_re_q),
            .c_im  (c_im_q),
            .valid (lane_valid[g]),
            .d_out (lane_data[g])
        );
    end

    mbt_rr_arbiter #(.LANES(LANES)) u_arb (
        .clk    (clk_fast),
        .rst    (rst),
        .req    (lane_req),
        .accept (load),
        .grant  (lane_grant)
    );

`ifdef MBT_PERF_CNT_EN
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (frame_acc) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
            if ((state_q == DISPATCH) && (&lane_busy_q) && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mbt_lane_engine.sv
// Bench for mbt_lane_engine on a 4x2 frame with two escape-time lanes,
// scored against a direct per-pixel escape-time model.
module tb_mbt_lane_engine;

    localparam int     Q = 21, N = 32, LANES = 2, H = 4, V = 2, AW = 3, IW = 7, SS = 7;
    localparam int     NPIX = H * V;
    localparam int     MAXI = 127;
    localparam longint LIM  = longint'(4) <<< (2 * Q);

    logic                clk_fast = 1'b0;
    logic                rst = 1'b1;
    logic                frame_start = 1'b0;
    logic signed [N-1:0] x_min = '0;
    logic signed [N-1:0] y_max = '0;
    logic [1:0]          zoom_level = '0;
    logic                busy, done, wr_valid;
    logic                wr_ready = 1'b1;
    logic [AW-1:0]       wr_addr;
    logic [IW-1:0]       wr_data;
`ifdef MBT_PERF_CNT_EN
    logic [31:0]         perf_cycles, perf_stall;
`endif

    mbt_lane_engine #(.Q(Q), .N(N), .LANES(LANES), .H_RES(H), .V_RES(V),
                      .ADDR_W(AW), .ITER_W(IW), .STEP_SHIFT(SS)) dut (
        .clk_fast    (clk_fast),
        .rst         (rst),
        .frame_start (frame_start),
        .x_min       (x_min),
        .y_max       (y_max),
        .zoom_level  (zoom_level),
        .busy        (busy),
        .done        (done),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
`ifdef MBT_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk_fast = ~clk_fast;

    int            total = 0, bad = 0;
    int            cyc = 0, fcyc = 0, nwr = 0, done_cnt = 0, last_acc = -10, busy_cnt = 0, rmode = 0;
    int            seen [NPIX];
    int            order[NPIX];
    int            exp_data[NPIX];
    bit            hold_chk = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [IW-1:0] hold_data;

    task automatic chk(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint wrapn(input longint v);
        return longint'(int'(v));
    endfunction

    function automatic int ref_iter(input longint cr, input longint ci);
        longint zr = 0, zi = 0, t;
        for (int n = 0; n < MAXI; n++) begin
            if (zr * zr + zi * zi > LIM) return n;
            t  = wrapn(((zr * zr - zi * zi) >>> Q) + cr);
            zi = wrapn(((2 * zr * zi) >>> Q) + ci);
            zr = t;
        end
        return MAXI;
    endfunction

    task automatic prep(input int xm, input int ym, input int zm);
        longint step;
        step = longint'(1) << (Q - SS - zm);
        for (int iy = 0; iy < V; iy++)
            for (int ix = 0; ix < H; ix++)
                exp_data[iy * H + ix] = ref_iter(wrapn(longint'(xm) + ix * step),
                                                 wrapn(longint'(ym) - iy * step));
        for (int p = 0; p < NPIX; p++) begin
            seen[p]  = 0;
            order[p] = -1;
        end
        nwr = 0; done_cnt = 0; busy_cnt = 0; fcyc = 0;
        x_min = xm; y_max = ym; zoom_level = 2'(zm);
    endtask

    // One clock: drive wr_ready for the coming edge, then score what it will transfer.
    task automatic tick();
        @(negedge clk_fast);
        cyc++;
        fcyc++;
        case (rmode)
            1:       wr_ready = ($urandom_range(0, 3) != 0);
            2:       wr_ready = !(fcyc >= 6 && fcyc < 26);
            default: wr_ready = 1'b1;
        endcase
        if (busy) busy_cnt++;
        if (hold_chk) begin
            chk("hold_valid", wr_valid, 1);
            chk("hold_addr", wr_addr, hold_addr);
            chk("hold_data", wr_data, hold_data);
        end
        hold_chk  = wr_valid && !wr_ready;
        hold_addr = wr_addr;
        hold_data = wr_data;
        if (done) begin
            done_cnt++;
            chk("done_after_last_write", cyc, last_acc + 1);
            chk("busy_at_done", busy, 0);
        end
        if (wr_valid && wr_ready) begin
            seen[wr_addr]++;
            order[wr_addr] = nwr;
            chk("wr_data", wr_data, exp_data[wr_addr]);
            nwr++;
            last_acc = cyc;
        end
    endtask

    task automatic run_frame(input int xm, input int ym, input int zm, input int mode,
                             input bit poke);
        prep(xm, ym, zm);
        rmode = mode;
        chk("busy_idle", busy, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("busy_rise", busy, 1);
        for (int t = 0; t < 4000 && done_cnt == 0; t++) begin
            if (poke && t == 5) begin
                frame_start = 1'b1;
                x_min = $urandom;
                y_max = $urandom;
                zoom_level = 2'($urandom_range(0, 3));
            end
            tick();
            frame_start = 1'b0;
        end
        chk("done_seen", done_cnt, 1);
        chk("write_count", nwr, NPIX);
        for (int p = 0; p < NPIX; p++) chk("seen_once", seen[p], 1);
`ifdef MBT_PERF_CNT_EN
        chk("perf_cycles", perf_cycles, busy_cnt);
        chk("perf_stall_bound", (perf_stall + NPIX <= perf_cycles), 1);
`endif
        tick();
        chk("done_width", done, 0);
        chk("busy_after", busy, 0);
        chk("no_extra_writes", nwr, NPIX);
    endtask

    initial begin
        rmode = 0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        tick();

        // c=(0,1) cycles forever while its neighbour escapes within a few steps.
        run_frame(0, 1 << Q, 0, 0, 1'b0);
        chk("pixel1_before_pixel0", (order[1] >= 0 && order[1] < order[0]), 1);

        // x_min=-2.0, y_max=1.0 with a 20-cycle wr_ready hold-off mid-frame.
        run_frame(-(2 << Q), 1 << Q, 0, 2, 1'b0);

        // frame_start and new inputs while busy must not disturb the frame.
        run_frame(-(3 << (Q - 2)), 1 << (Q - 3), 1, 1, 1'b1);

        for (int f = 0; f < 3; f++)
            run_frame(int'($urandom_range(0, 5242880)) - 4194304,
                      int'($urandom_range(0, 5033164)) - 2516582,
                      int'($urandom_range(0, 3)), 1, 1'b0);

        // Reset in the middle of a frame, then a clean frame afterwards.
        prep(0, 1 << Q, 0);
        rmode = 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int t = 0; t < 12; t++) tick();
        @(posedge clk_fast);
        #2;
        rst = 1'b1;
        hold_chk = 1'b0;
        #1;
        chk("midrst_wr_valid", wr_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        tick();
        hold_chk = 1'b0;
        rst = 1'b0;
        tick();
        chk("postrst_busy", busy, 0);
        run_frame(-(1 << Q), 1 << (Q - 1), 2, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
